// File: rtl/vcve2_fetch_queue.sv
// vcve2_fetch_queue: instruction-side bus master and word FIFO that feeds
// halfword-aligned instructions to the IF stage.
module vcve2_fetch_queue #(
   parameter int NumOutstanding = 2,
   parameter int Depth = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] addr_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] rdata_o,
   output logic [31:0] addr_o,
   output logic        err_o,
   output logic        err_plus2_o,
   output logic        busy_o,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i
);
   localparam int CW = $clog2(Depth + NumOutstanding + 2);
   localparam logic [CW-1:0] L_NO = CW'(NumOutstanding);
   localparam logic [CW-1:0] L_DEPTH = CW'(Depth);
   localparam int E1 = (Depth > 1) ? 1 : 0;
   logic [31:0] r_fetch_addr, r_tgt, r_addr;
   logic        r_pend, r_tgt_v;
   logic [CW-1:0] r_out, r_disc, r_cnt, w_cnt;
   logic [32:0] r_mem [Depth];
   logic [32:0] w_mem [Depth];
   logic [32:0] w_e0;
   logic [15:0] w_e1_lo;
   logic        w_e1_err, w_has0, w_has1, w_need1, w_gnt, w_push, w_hs, w_pop, w_unused;
   assign w_unused = addr_i[0];
   // A request held without grant keeps the bus stable regardless of req_i/branch_i.
   assign instr_req_o = r_pend | (req_i & ~branch_i & (r_out < L_NO) & (r_cnt + r_out < L_DEPTH));
   assign instr_addr_o = r_fetch_addr;
   assign busy_o = instr_req_o | (r_out != '0);
   assign addr_o = r_addr;
   always_comb begin
      w_e0 = r_mem[0];
      w_e1_lo = r_mem[E1][15:0];
      w_e1_err = r_mem[E1][32];
      w_has0 = r_cnt != '0;
      w_has1 = r_cnt > CW'(1);
      w_need1 = r_addr[1] & (w_e0[17:16] == 2'b11) & ~w_e0[32];
      valid_o = w_has0 & (~w_need1 | w_has1);
      rdata_o = r_addr[1] ? {w_e1_lo, w_e0[31:16]} : w_e0[31:0];
      err_o = w_has0 & w_e0[32];
      err_plus2_o = w_has1 & w_need1 & w_e1_err;
      w_gnt = instr_req_o & instr_gnt_i;
      w_push = instr_rvalid_i & (r_disc == '0) & ~branch_i;
      w_hs = valid_o & ready_i & ~branch_i;
      // Pop once the handshake leaves the current word.
      w_pop = w_hs & (r_addr[1] | (rdata_o[1:0] == 2'b11));
      w_mem = r_mem;
      w_cnt = r_cnt;
      if (w_pop) begin
         for (int i = 0; i < Depth - 1; i++) w_mem[i] = r_mem[i + 1];
         w_cnt = r_cnt - CW'(1);
      end
      for (int i = 0; i < Depth; i++) if (w_push && CW'(i) == w_cnt) w_mem[i] = {instr_err_i, instr_rdata_i};
      w_cnt = branch_i ? '0 : w_cnt + CW'(w_push);
   end
   always_ff @(posedge clk_i) r_mem <= w_mem;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fetch_addr <= '0;
         r_tgt <= '0;
         r_tgt_v <= 1'b0;
         r_addr <= '0;
         r_pend <= 1'b0;
         r_out <= '0;
         r_disc <= '0;
         r_cnt <= '0;
      end else begin
         r_pend <= instr_req_o & ~instr_gnt_i;
         r_out <= r_out + CW'(w_gnt) - CW'(instr_rvalid_i);
         r_cnt <= w_cnt;
         r_disc <= branch_i ? r_out - CW'(instr_rvalid_i) + CW'(r_pend)
                            : r_disc - CW'(instr_rvalid_i && r_disc != '0);
         r_addr <= branch_i ? {addr_i[31:1], 1'b0}
                 : w_hs ? r_addr + ((rdata_o[1:0] == 2'b11) ? 32'd4 : 32'd2) : r_addr;
         // A branch during a stalled request parks its target until that grant.
         r_tgt_v <= (branch_i & r_pend & ~instr_gnt_i) | (r_tgt_v & ~branch_i & ~w_gnt);
         r_tgt <= branch_i ? {addr_i[31:2], 2'b00} : r_tgt;
         r_fetch_addr <= branch_i ? ((r_pend & ~instr_gnt_i) ? r_fetch_addr : {addr_i[31:2], 2'b00})
                       : w_gnt ? (r_tgt_v ? r_tgt : r_fetch_addr + 32'd4) : r_fetch_addr;
      end
   end
endmodule

// File: tb/tb_vcve2_fetch_queue.sv
// tb_vcve2_fetch_queue: directed and random checks of the fetch queue against
// an instruction-stream model and a randomized memory/bus responder.
module tb_vcve2_fetch_queue;
   localparam int NO = 2;
   logic clk = 1'b0, rst_i = 1'b1, req_i = 1'b0, branch_i = 1'b0, ready_i = 1'b0;
   logic [31:0] addr_i = '0, instr_rdata_i = '0;
   logic instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
   logic valid_o, err_o, err_plus2_o, busy_o, instr_req_o;
   logic [31:0] rdata_o, addr_o, instr_addr_o;
   always #5 clk = ~clk;
   vcve2_fetch_queue #(.NumOutstanding(NO), .Depth(3)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
      .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o),
      .err_o(err_o), .err_plus2_o(err_plus2_o), .busy_o(busy_o),
      .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
      .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i));
   typedef struct {logic [31:0] a; logic [31:0] d; logic e; logic p;} hs_t;
   hs_t hs_log[$];
   logic [31:0] glog[$], bq[$];
   logic [32:0] mem [logic [31:0]];
   int n_chk = 0, n_err = 0, n_hs = 0;
   int gnt_pct = 100, rv_pct = 100, rdy_pct = 100;
   bit req_en = 0, armed = 0, prev_ng = 0, stale = 0;
   logic [31:0] prev_ga = '0, exp_pc = '0, exp_fa = '0;
   logic obs_req, obs_valid, obs_err, obs_ep2, obs_busy;
   logic [31:0] obs_iaddr, obs_addr, obs_rdata;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // Memory: explicit words override a hash; bit 32 is the bus error flag.
   function automatic logic [32:0] memw(input logic [31:0] a);
      logic [31:0] k, x;
      k = {a[31:2], 2'b00};
      if (mem.exists(k)) return mem[k];
      x = k * 32'h9E3779B1;
      x ^= x >> 15;
      x = x * 32'h85EBCA6B;
      x ^= x >> 13;
      return {x[31:28] == 4'h0, x};
   endfunction
   task automatic tick(input bit br, input logic [31:0] ba, input bit rs);
      logic [32:0] w0, w1, r;
      logic [15:0] lo, hi;
      logic unc, e0, e1, full, hs, rq, g, rv;
      logic [31:0] ga;
      unc = 1'b0;
      @(negedge clk);
      rst_i = rs; branch_i = br; addr_i = ba; req_i = req_en;
      ready_i = ($urandom_range(99) < rdy_pct);
      instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
      #1;
      obs_req = instr_req_o; obs_iaddr = instr_addr_o; obs_valid = valid_o; obs_addr = addr_o;
      obs_rdata = rdata_o; obs_err = err_o; obs_ep2 = err_plus2_o; obs_busy = busy_o;
      if (armed) begin
         chk("busy", busy_o, instr_req_o | (bq.size() != 0));
         if (prev_ng) begin
            chk("req_hold", instr_req_o, 1);
            chk("addr_hold", instr_addr_o, prev_ga);
         end
         if (valid_o) begin
            w0 = memw(exp_pc);
            lo = exp_pc[1] ? w0[31:16] : w0[15:0];
            unc = lo[1:0] == 2'b11;
            e0 = w0[32];
            w1 = memw(exp_pc + 32'd2);
            hi = exp_pc[1] ? w1[15:0] : w0[31:16];
            e1 = exp_pc[1] & w1[32];
            full = unc & ~(exp_pc[1] & e0);
            chk("v_addr", addr_o, exp_pc);
            chk("v_data", full ? rdata_o : {16'h0, rdata_o[15:0]}, full ? {hi, lo} : {16'h0, lo});
            chk("v_err", err_o, e0);
            chk("v_errp2", err_plus2_o, unc & exp_pc[1] & ~e0 & e1);
         end
      end
      if (!rs) begin
         instr_gnt_i = instr_req_o && ($urandom_range(99) < gnt_pct);
         if (bq.size() != 0 && $urandom_range(99) < rv_pct) begin
            r = memw(bq[0]);
            instr_rvalid_i = 1'b1; instr_rdata_i = r[31:0]; instr_err_i = r[32];
         end
      end
      hs = valid_o & ready_i & ~br & ~rs;
      rq = instr_req_o; g = instr_gnt_i; ga = instr_addr_o; rv = instr_rvalid_i;
      @(posedge clk);
      if (rs) begin
         armed = 1; prev_ng = 0; stale = 0; exp_pc = '0; exp_fa = '0;
         bq.delete();
      end else begin
         if (g) begin
            chk("out_limit", bq.size() < NO, 1);
            if (stale) stale = 0;
            else begin
               chk("gnt_addr", ga, exp_fa);
               exp_fa += 32'd4;
            end
         end
         if (rv) void'(bq.pop_front());
         if (g) begin
            bq.push_back(ga);
            glog.push_back(ga);
         end
         if (hs) begin
            hs_log.push_back('{obs_addr, obs_rdata, obs_err, obs_ep2});
            exp_pc += unc ? 32'd4 : 32'd2;
            n_hs++;
         end
         if (br) begin
            exp_pc = {ba[31:1], 1'b0};
            exp_fa = {ba[31:2], 2'b00};
            stale = rq & ~g;
         end
         prev_ng = rq & ~g;
         prev_ga = ga;
      end
   endtask
   task automatic drain();
      req_en = 0; gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
      tick(1, 32'hF000, 0);
      repeat (8) tick(0, 0, 0);
      hs_log.delete();
      glog.delete();
   endtask
   task automatic chk_reset(input string p);
      chk({p, "_req"}, obs_req, 0);
      chk({p, "_valid"}, obs_valid, 0);
      chk({p, "_addr"}, obs_addr, 0);
      chk({p, "_err"}, obs_err, 0);
      chk({p, "_errp2"}, obs_ep2, 0);
      chk({p, "_busy"}, obs_busy, 0);
   endtask
   initial begin
      mem[32'h100] = {1'b0, 32'h0000_0013};
      tick(0, 0, 1);
      tick(0, 0, 1);
      tick(0, 0, 0);
      chk_reset("rst");
      // Minimum latency after a branch.
      req_en = 1;
      tick(1, 32'h100, 0);
      tick(0, 0, 0);
      chk("t1_req", obs_req, 1);
      chk("t1_iaddr", obs_iaddr, 32'h100);
      chk("t1_valid1", obs_valid, 0);
      tick(0, 0, 0);
      chk("t1_valid2", obs_valid, 0);
      tick(0, 0, 0);
      chk("t1_valid3", obs_valid, 1);
      chk("t1_addr", obs_addr, 32'h100);
      chk("t1_data", obs_rdata, 32'h13);
      // Unaligned branch onto a compressed upper half.
      drain();
      mem[32'h100] = {1'b0, 32'h0000_4501};
      mem[32'h104] = {1'b0, 32'h0513_0093};
      req_en = 1;
      tick(1, 32'h102, 0);
      repeat (12) tick(0, 0, 0);
      chk("t2_a0", hs_log[0].a, 32'h102);
      chk("t2_d0", {16'h0, hs_log[0].d[15:0]}, 32'h0);
      chk("t2_a1", hs_log[1].a, 32'h104);
      chk("t2_d1", hs_log[1].d, 32'h0513_0093);
      // Unaligned uncompressed spanning two words, error on the second word.
      drain();
      mem[32'h200] = {1'b0, 32'h0093_1111};
      mem[32'h204] = {1'b1, 32'h0001_0513};
      req_en = 1;
      tick(1, 32'h202, 0);
      repeat (12) tick(0, 0, 0);
      chk("t3_a0", hs_log[0].a, 32'h202);
      chk("t3_d0", hs_log[0].d, 32'h0513_0093);
      chk("t3_e0", hs_log[0].e, 0);
      chk("t3_p0", hs_log[0].p, 1);
      chk("t3_a1", hs_log[1].a, 32'h206);
      chk("t3_e1", hs_log[1].e, 1);
      // Branch with two responses in flight.
      drain();
      req_en = 1; rv_pct = 0;
      tick(1, 32'h300, 0);
      repeat (3) tick(0, 0, 0);
      chk("t4_block", obs_req, 0);
      tick(1, 32'h400, 0);
      rv_pct = 100;
      repeat (12) tick(0, 0, 0);
      chk("t4_g2", glog[2], 32'h400);
      chk("t4_a0", hs_log[0].a, 32'h400);
      // Branch while a request waits for grant.
      drain();
      req_en = 1; gnt_pct = 0;
      tick(1, 32'h500, 0);
      tick(0, 0, 0);
      chk("t5_req", obs_req, 1);
      tick(1, 32'h400, 0);
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0);
         chk("t5_hold", obs_iaddr, 32'h500);
      end
      gnt_pct = 100;
      repeat (12) tick(0, 0, 0);
      chk("t5_g0", glog[0], 32'h500);
      chk("t5_g1", glog[1], 32'h400);
      chk("t5_g2", glog[2], 32'h404);
      chk("t5_a0", hs_log[0].a, 32'h400);
      // Back-pressure fills the FIFO, then reset mid-stream.
      drain();
      req_en = 1; rdy_pct = 0;
      tick(1, 32'h600, 0);
      repeat (15) tick(0, 0, 0);
      chk("t6_fetched", glog.size(), 3);
      chk("t6_req", obs_req, 0);
      chk("t6_valid", obs_valid, 1);
      rdy_pct = 100;
      repeat (10) tick(0, 0, 0);
      chk("t6_resume", glog.size() > 3, 1);
      req_en = 0;
      tick(0, 0, 1);
      tick(0, 0, 0);
      chk_reset("mid_rst");
      // Random bus timing, back-pressure, fetch enable and redirects.
      n_hs = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) begin
            gnt_pct = $urandom_range(30, 100);
            rv_pct = $urandom_range(30, 100);
            rdy_pct = $urandom_range(20, 100);
         end
         req_en = ($urandom_range(99) < 92);
         if ($urandom_range(99) < 4) tick(1, 32'($urandom_range(0, 16383)), 0);
         else tick(0, 0, 0);
      end
      chk("rand_progress", n_hs > 100, 1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
